// File: rtl/select_mode_fsm.sv
// Game-mode selector: synchronised, debounced one-hot switch choice drives a registered one-hot screen select.
// Define SELECT_GAME_LOCK_EN to hold the chosen mode for the whole session (until game_over or reset).
module select_mode_fsm #(
  parameter int SW_W            = 16,
  parameter int N_MODES         = 2,
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int IDX_W           = $clog2(N_MODES)
) (
  input  logic               clk65MHz,
  input  logic               rst_n,
  input  logic [SW_W-1:0]    sw,
  input  logic               game_over,
  output logic               screen_idle,
  output logic [N_MODES-1:0] screen_mode,
  output logic [IDX_W-1:0]   mode_idx,
  output logic               mode_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;

  logic [N_MODES-1:0] sw_meta, sw_s, sw_prev, sw_db;
  logic [CNT_W-1:0]   db_cnt, db_cnt_n;
  logic               sel_ok;
  logic [IDX_W-1:0]   sel_idx;
  state_t             state, state_n;
  logic [IDX_W-1:0]   mode_q, mode_n;
  logic               chg_n;
  logic               sw_unused;

  // Switches above N_MODES are not mode selects.
  assign sw_unused = ^sw;

  // db_cnt counts consecutive cycles sw_s has held its value, including the cycle it changed.
  always_comb begin
    db_cnt_n = db_cnt;
    if (sw_s != sw_prev) begin
      db_cnt_n = CNT_W'(1);
    end else if (db_cnt != DB_MAX) begin
      db_cnt_n = db_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_s    <= '0;
      sw_prev <= '0;
      sw_db   <= '0;
      db_cnt  <= '0;
    end else begin
      sw_meta <= sw[N_MODES-1:0];
      sw_s    <= sw_meta;
      sw_prev <= sw_s;
      db_cnt  <= db_cnt_n;
      if (db_cnt_n == DB_MAX) begin
        sw_db <= sw_s;
      end
    end
  end

  always_comb begin
    sel_ok  = (sw_db != '0) && ((sw_db & (sw_db - N_MODES'(1))) == '0);
    sel_idx = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if (sw_db[k]) begin
        sel_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    chg_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_ok) begin
          state_n = ST_PLAY;
          mode_n  = sel_idx;
          chg_n   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (game_over) begin
          state_n = ST_DONE;
        end
`ifdef SELECT_GAME_LOCK_EN
        // Switch changes are ignored until the session ends.
`else
        else if (!sel_ok) begin
          state_n = ST_IDLE;
        end else if (sel_idx != mode_q) begin
          mode_n = sel_idx;
          chg_n  = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        // Wait for all switches released so a held switch cannot restart the game.
        if (sw_db == '0) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_q      <= '0;
      screen_idle <= 1'b1;
      screen_mode <= '0;
      mode_idx    <= '0;
      mode_change <= 1'b0;
    end else begin
      state       <= state_n;
      mode_q      <= mode_n;
      screen_idle <= (state_n != ST_PLAY);
      screen_mode <= (state_n == ST_PLAY) ? (N_MODES'(1) << mode_n) : '0;
      mode_idx    <= (state_n == ST_PLAY) ? mode_n : '0;
      mode_change <= chg_n;
    end
  end

endmodule

// File: tb/tb_select_mode_fsm.sv
// Directed bench for select_mode_fsm (3 modes, debounce 4) with a history-based reference model.
module tb_select_mode_fsm;

  localparam int SW_W    = 16;
  localparam int N_MODES = 3;
  localparam int DB      = 4;
  localparam int IDX_W   = 2;

  logic               clk65MHz  = 1'b0;
  logic               rst_n     = 1'b0;
  logic               game_over = 1'b0;
  logic [SW_W-1:0]    sw        = '0;
  logic               screen_idle;
  logic [N_MODES-1:0] screen_mode;
  logic [IDX_W-1:0]   mode_idx;
  logic               mode_change;

  int n_cmp    = 0;
  int n_bad    = 0;
  int chg_seen = 0;
  int base;
  bit running  = 1'b1;

  select_mode_fsm #(
    .SW_W(SW_W), .N_MODES(N_MODES), .DEBOUNCE_CYCLES(DB), .IDX_W(IDX_W)
  ) dut (
    .clk65MHz(clk65MHz), .rst_n(rst_n), .sw(sw), .game_over(game_over),
    .screen_idle(screen_idle), .screen_mode(screen_mode),
    .mode_idx(mode_idx), .mode_change(mode_change)
  );

  always #5 clk65MHz = ~clk65MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw switch samples per edge, mode as an integer (-1 = menu shown).
  logic [N_MODES-1:0] hist[$];
  logic [N_MODES-1:0] m_db;
  int                 m_mode;
  bit                 m_done;
  bit                 m_chg;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back('0);
    m_db   = '0;
    m_mode = -1;
    m_done = 1'b0;
    m_chg  = 1'b0;
  endfunction

  function automatic void model_step();
    int sel, old;
    logic [N_MODES-1:0] cur;
    bit stable;
    sel = -1;
    if ($countones(m_db) == 1)
      for (int k = 0; k < N_MODES; k++) if (m_db[k]) sel = k;
    old = m_mode;
    if (m_mode >= 0) begin
      if (game_over) begin
        m_mode = -1;
        m_done = 1'b1;
      end
`ifdef SELECT_GAME_LOCK_EN
`else
      else m_mode = sel;
`endif
    end else if (m_done) begin
      if (m_db == '0) m_done = 1'b0;
    end else begin
      m_mode = sel;
    end
    m_chg = (m_mode >= 0) && (m_mode != old);
    // The switch value seen two edges ago is accepted once it has held for DB edges.
    hist.push_back(sw[N_MODES-1:0]);
    void'(hist.pop_front());
    cur    = hist[hist.size()-3];
    stable = 1'b1;
    for (int i = 3; i <= DB + 2; i++) if (hist[hist.size()-i] !== cur) stable = 1'b0;
    if (stable) m_db = cur;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk65MHz or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk65MHz);
      if (running) begin
        chk("screen_idle", 32'(screen_idle), 32'(m_mode < 0));
        chk("screen_mode", 32'(screen_mode), (m_mode < 0) ? 0 : (1 << m_mode));
        chk("mode_idx", 32'(mode_idx), (m_mode < 0) ? 0 : m_mode);
        chk("mode_change", 32'(mode_change), 32'(m_chg));
        chk("exclusive", 32'($countones({screen_idle, screen_mode})), 1);
        if (mode_change) chg_seen++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk65MHz);
    #1;
  endtask

  initial begin
    sw = 16'h0002;
    step(3);
    chk("rst_idle", 32'(screen_idle), 1);
    chk("rst_mode", 32'(screen_mode), 0);
    chk("rst_idx", 32'(mode_idx), 0);
    chk("rst_chg", 32'(mode_change), 0);
    rst_n = 1'b1;
    step(6);
    chk("lat_idle6", 32'(screen_idle), 1);
    chk("lat_chg6", 32'(mode_change), 0);
    step(1);
    chk("lat_mode7", 32'(screen_mode), 2);
    chk("lat_idx7", 32'(mode_idx), 1);
    chk("lat_chg7", 32'(mode_change), 1);
    step(1);
    chk("lat_chg8", 32'(mode_change), 0);

    game_over = 1'b1; step(1); game_over = 1'b0;
    chk("go_idle", 32'(screen_idle), 1);
    sw = 16'h0000; step(10);

    base = chg_seen;
    sw = 16'h0001; step(3); sw = 16'h0000; step(12);
    chk("glitch_idle", 32'(screen_idle), 1);
    chk("glitch_pulses", 32'(chg_seen - base), 0);

    sw = 16'h0003; step(10);
    chk("multi_mode", 32'(screen_mode), 0);
    sw = 16'h0000; step(10);
    chk("multi_idle", 32'(screen_idle), 1);

    sw = 16'h0004; step(7);
    chk("m2_mode", 32'(screen_mode), 4);
    chk("m2_idx", 32'(mode_idx), 2);
    game_over = 1'b1; sw = 16'h0006; step(1); game_over = 1'b0; sw = 16'h0004;
    chk("done_idle", 32'(screen_idle), 1);
    chk("done_idx", 32'(mode_idx), 0);
    step(12);
    chk("done_hold", 32'(screen_idle), 1);
    sw = 16'h0000; step(7);
    sw = 16'h0001; step(7);
    chk("m0_mode", 32'(screen_mode), 1);
    chk("m0_chg", 32'(mode_change), 1);

    sw = 16'h0002; step(6);
    chk("sw_idx6", 32'(mode_idx), 0);
    step(1);
`ifdef SELECT_GAME_LOCK_EN
    chk("lock_idx", 32'(mode_idx), 0);
    chk("lock_mode", 32'(screen_mode), 1);
    chk("lock_chg", 32'(mode_change), 0);
`else
    chk("swap_idx", 32'(mode_idx), 1);
    chk("swap_mode", 32'(screen_mode), 2);
    chk("swap_chg", 32'(mode_change), 1);
    step(1);
    chk("swap_chg_end", 32'(mode_change), 0);
    sw = 16'h0006; step(7);
    chk("multi_play_idle", 32'(screen_idle), 1);
`endif
    game_over = 1'b1; sw = 16'h0000; step(1); game_over = 1'b0;
    step(10);

    sw = 16'h0001; step(7);
    chk("re_mode", 32'(screen_mode), 1);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("arst_idle", 32'(screen_idle), 1);
    chk("arst_mode", 32'(screen_mode), 0);
    chk("arst_chg", 32'(mode_change), 0);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("post_rst_idle", 32'(screen_idle), 1);
    step(1);
    chk("post_rst_mode", 32'(screen_mode), 1);
    chk("post_rst_chg", 32'(mode_change), 1);
    step(2);

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
